fft_bitrev_reorder: RTL and testbench

//  Output-side reorder buffer for the radix-2^2 SDF FFT. The FFT emits a

---
 rtl/fft_bitrev_reorder.sv | 168 ++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder
// Brief    : Ping-pong reorder buffer turning bit-reversed FFT output frames
//            into natural-order frames on a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module fft_bitrev_reorder #(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = 25
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sync_i,
    input  logic [$clog2(N)-1:0]    ctr_i,
    input  logic [DATA_WIDTH-1:0]   data_re_i,
    input  logic [DATA_WIDTH-1:0]   data_im_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [$clog2(N)-1:0]    bin_o,
    output logic                    last_o,
    output logic [DATA_WIDTH-1:0]   data_re_o,
    output logic [DATA_WIDTH-1:0]   data_im_o,
    output logic                    overflow_o
);

    localparam int                 N_LOG2   = $clog2(N);
    localparam int                 MEM_W    = 2 * DATA_WIDTH;
    localparam logic [N_LOG2-1:0]  LAST_IDX = N_LOG2'(N - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    logic [MEM_W-1:0] mem [0:2*N-1];

    // write side
    logic [N_LOG2-1:0] wr_cnt_q;
    logic              wr_bank_q;
    logic              drop_q;
    logic              overflow_q;
    logic [1:0]        full_q, full_d;

    // read side
    state_t            state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [N_LOG2-1:0] rd_addr_q, rd_addr_d;
    logic              s1_valid_q;
    logic [N_LOG2-1:0] s1_bin_q;
    logic [MEM_W-1:0]  s1_data_q;
    logic              out_valid_q;
    logic [N_LOG2-1:0] out_bin_q;
    logic              out_last_q;
    logic [MEM_W-1:0]  out_data_q;

    logic              w_s2_ready, w_s1_ready;
    logic              w_issue;
    logic [1:0]        w_clr, w_set, w_full_eff;
    logic              w_start, w_drop, w_we, w_wr_last;

    assign w_s2_ready = !out_valid_q || ready_i;
    assign w_s1_ready = !s1_valid_q || w_s2_ready;

    // A bank is released once its last word has been read out of the RAM; the
    // remaining words already sit in the output pipeline registers.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        w_issue   = 1'b0;
        w_clr     = 2'b00;
        if (full_q[rd_bank_q] && w_s1_ready) begin
            w_issue = 1'b1;
            if (rd_addr_q == LAST_IDX) begin
                w_clr     = rd_bank_q ? 2'b10 : 2'b01;
                rd_bank_d = ~rd_bank_q;
                rd_addr_d = '0;
                state_d   = full_q[~rd_bank_q] ? ST_READ : ST_IDLE;
            end else begin
                rd_addr_d = rd_addr_q + N_LOG2'(1);
                state_d   = ST_READ;
            end
        end
    end

    always_comb begin
        w_full_eff = full_q & ~w_clr;
        w_start    = (wr_cnt_q == '0);
        w_drop     = w_start ? w_full_eff[wr_bank_q] : drop_q;
        w_we       = sync_i && !w_drop;
        w_wr_last  = sync_i && (wr_cnt_q == LAST_IDX);
        w_set      = 2'b00;
        if (w_wr_last && !w_drop) begin
            w_set = wr_bank_q ? 2'b10 : 2'b01;
        end
        full_d = w_full_eff | w_set;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            drop_q      <= 1'b0;
            overflow_q  <= 1'b0;
            full_q      <= 2'b00;
            state_q     <= ST_IDLE;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_bin_q    <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            full_q    <= full_d;
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
            if (sync_i) begin
                wr_cnt_q <= (wr_cnt_q == LAST_IDX) ? '0 : wr_cnt_q + N_LOG2'(1);
                drop_q   <= w_drop;
                if (w_start && w_drop) begin
                    overflow_q <= 1'b1;
                end
                if (w_wr_last && !w_drop) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            if (w_s1_ready) begin
                s1_valid_q <= w_issue;
                if (w_issue) begin
                    s1_bin_q <= rd_addr_q;
                end
            end
            if (w_s2_ready) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_bin_q  <= s1_bin_q;
                    out_last_q <= (s1_bin_q == LAST_IDX);
                end
            end
        end
    end

    // Storage and data path registers carry no reset; qualifiers gate them.
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            mem[{wr_bank_q, ctr_i}] <= {data_re_i, data_im_i};
        end
        if (w_issue) begin
            s1_data_q <= mem[{rd_bank_q, rd_addr_q}];
        end
        if (w_s2_ready && s1_valid_q) begin
            out_data_q <= s1_data_q;
        end
    end

    assign valid_o    = out_valid_q;
    assign bin_o      = out_bin_q;
    assign last_o     = out_valid_q && out_last_q;
    assign data_re_o  = out_data_q[MEM_W-1:DATA_WIDTH];
    assign data_im_o  = out_data_q[DATA_WIDTH-1:0];
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_bitrev_reorder
// Brief    : Directed/table-driven self-checking bench for fft_bitrev_reorder.
// Revision : 1.0  initial release
// ============================================================================
module tb_fft_bitrev_reorder;

    localparam int N  = 16;
    localparam int NL = 4;
    localparam int DW = 25;

    logic          clk;
    logic          rst_i;
    logic          sync_i;
    logic [NL-1:0] ctr_i;
    logic [DW-1:0] data_re_i, data_im_i;
    logic          valid_o, ready_i, last_o, overflow_o;
    logic [NL-1:0] bin_o;
    logic [DW-1:0] data_re_o, data_im_o;

    fft_bitrev_reorder #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .sync_i(sync_i), .ctr_i(ctr_i),
        .data_re_i(data_re_i), .data_im_i(data_im_i),
        .valid_o(valid_o), .ready_i(ready_i), .bin_o(bin_o), .last_o(last_o),
        .data_re_o(data_re_o), .data_im_o(data_im_o), .overflow_o(overflow_o)
    );

    typedef struct {
        logic [NL-1:0] bin;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
        int            cyc;
    } rx_t;

    typedef struct {
        string name;
        int    nfr;
        int    gap_at;
        int    gap_len;
        int    stall_len;
        int    start_dly;
        int    drop_frame;
        bit    exp_ovf;
    } scen_t;

    int  n_cmp = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  t_last = 0;
    int  first_valid_cyc = -1;
    int  rdy_mode = 0;
    rx_t rx[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ready_i: 0 = always ready, 1 = random 50%, 2 = held low
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       ready_i = 1'b1;
                1:       ready_i = 1'($urandom_range(0, 1));
                default: ready_i = 1'b0;
            endcase
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Output monitor: records transfers and checks hold-stability under stall.
    initial begin
        bit            hold;
        logic [NL-1:0] h_bin;
        logic [DW-1:0] h_re, h_im;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_hold", {valid_o, bin_o, data_re_o, data_im_o},
                        {1'b1, h_bin, h_re, h_im});
                end
                if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (valid_o && ready_i)
                    rx.push_back('{bin: bin_o, re: data_re_o, im: data_im_o,
                                   last: last_o, cyc: cyc});
                hold  = valid_o && !ready_i;
                h_bin = bin_o;
                h_re  = data_re_o;
                h_im  = data_im_o;
            end
        end
    end

    function automatic logic [NL-1:0] bitrev(input int i);
        logic [NL-1:0] v, r;
        v = NL'(i);
        for (int b = 0; b < NL; b++) r[b] = v[NL-1-b];
        return r;
    endfunction

    // Frame 0 carries re=k, im=-k; other frames carry hashed values.
    function automatic logic [DW-1:0] vre(input int f, input int k);
        if (f == 0) return DW'(k);
        return DW'(f * 40503 + k * 9973 + 12345) ^ DW'(f << 13);
    endfunction

    function automatic logic [DW-1:0] vim(input int f, input int k);
        if (f == 0) return DW'(-k);
        return DW'(((f * 7919) ^ (k * 104729)) + 777);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i  = 1'b1;
        sync_i = 1'b0;
        repeat (3) step();
        rst_i = 1'b0;
    endtask

    task automatic drive_frame(input int f, input int gap_at, input int gap_len);
        for (int i = 0; i < N; i++) begin
            if (i == gap_at) begin
                sync_i = 1'b0;
                repeat (gap_len) step();
            end
            sync_i    = 1'b1;
            ctr_i     = bitrev(i);
            data_re_i = vre(f, int'(bitrev(i)));
            data_im_i = vim(f, int'(bitrev(i)));
            t_last    = cyc;
            step();
        end
        sync_i = 1'b0;
    endtask

    task automatic wait_out(input int n, input string nm);
        int b = 0;
        while (rx.size() < n && b < 3000) begin
            step();
            b++;
        end
        if (rx.size() < n) chk({nm, "_timeout"}, rx.size(), n);
        repeat (30) step();
    endtask

    task automatic check_frames(input int fids[$], input bit gapless, input string nm);
        int nexp = fids.size() * N;
        chk({nm, "_count"}, rx.size(), nexp);
        for (int i = 0; i < nexp && i < rx.size(); i++) begin
            int f = fids[i / N];
            int k = i % N;
            chk({nm, "_bin"}, rx[i].bin, k);
            chk({nm, "_re"},  rx[i].re, vre(f, k));
            chk({nm, "_im"},  rx[i].im, vim(f, k));
            chk({nm, "_last"}, rx[i].last, (k == N - 1));
            if (gapless) chk({nm, "_gap"}, rx[i].cyc - rx[0].cyc, i);
        end
    endtask

    initial begin
        scen_t sc[4];
        int    fids[$];

        sc[0] = '{"single",  1, -1, 0,  0,  0, -1, 1'b0};
        sc[1] = '{"b2b4",    4, -1, 0,  0,  0, -1, 1'b0};
        sc[2] = '{"stall40", 6, -1, 0, 40, 12,  2, 1'b1};
        sc[3] = '{"gap5",    1,  7, 5,  0,  0, -1, 1'b0};

        sync_i = 1'b0; ctr_i = '0; data_re_i = '0; data_im_i = '0;
        do_reset();
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_bin", bin_o, 0);
        chk("rst_ovf", overflow_o, 0);

        for (int s = 0; s < 4; s++) begin
            rdy_mode = (sc[s].stall_len > 0) ? 2 : 0;
            do_reset();
            rx.delete();
            first_valid_cyc = -1;
            fork
                begin
                    repeat (sc[s].stall_len) step();
                    rdy_mode = 0;
                end
                begin
                    repeat (sc[s].start_dly) step();
                    for (int f = 0; f < sc[s].nfr; f++)
                        drive_frame(f, sc[s].gap_at, sc[s].gap_len);
                end
            join
            fids.delete();
            for (int f = 0; f < sc[s].nfr; f++)
                if (f != sc[s].drop_frame) fids.push_back(f);
            wait_out(fids.size() * N, sc[s].name);
            check_frames(fids, sc[s].stall_len == 0, sc[s].name);
            chk({sc[s].name, "_ovf"}, overflow_o, sc[s].exp_ovf);
            if (sc[s].nfr == 1) chk({sc[s].name, "_latency"}, first_valid_cyc - t_last, 3);
        end

        // Reset in the middle of the read-out, with overflow already sticky.
        rdy_mode = 2;
        do_reset();
        for (int f = 200; f < 203; f++) drive_frame(f, -1, 0);
        chk("rstmid_ovf_pre", overflow_o, 1);
        rdy_mode = 0;
        begin
            int b = 0;
            while (!(valid_o && bin_o == 4'd6) && b < 200) begin
                step();
                b++;
            end
            chk("rstmid_reach_bin6", {valid_o, bin_o}, {1'b1, 4'd6});
        end
        rst_i = 1'b1;
        step();
        chk("rstmid_valid", valid_o, 0);
        chk("rstmid_ovf", overflow_o, 0);
        rst_i = 1'b0;
        rx.delete();
        drive_frame(210, -1, 0);
        wait_out(N, "rstmid");
        fids.delete();
        fids.push_back(210);
        check_frames(fids, 1'b1, "rstmid");

        // Random backpressure with input paced below the output rate.
        rdy_mode = 1;
        do_reset();
        rx.delete();
        fids.delete();
        for (int f = 100; f < 140; f++) begin
            drive_frame(f, -1, 0);
            fids.push_back(f);
            repeat (32) step();
        end
        wait_out(fids.size() * N, "rand");
        check_frames(fids, 1'b0, "rand");
        chk("rand_ovf", overflow_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
